wb_arbiter: RTL



---
 rtl/wb_arb_pkg.sv | 35 +++
 rtl/wb_if.sv | 28 ++
 rtl/wb_arb_rr.sv | 30 +++
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, bus widths and round-robin helper for wb_arbiter
package wb_arb_pkg;

  localparam int WB_AW       = 32;
  localparam int WB_DW       = 32;
  localparam int WB_SW       = WB_DW / 8;
  localparam int MAX_MASTERS = 8;
  localparam int RR_IW       = $clog2(MAX_MASTERS);

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  // Scan downward so the lowest offset from last wins: order is last+1, last+2, ...
  function automatic logic [RR_IW-1:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                               input logic [RR_IW-1:0]       last,
                                               input int                     n);
    logic [RR_IW-1:0] win;
    int               idx;
    win = last;
    for (int k = MAX_MASTERS; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (req[idx[RR_IW-1:0]]) win = RR_IW'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - Wishbone pipelined-mode bus; signal names are from the bus master's point of view
interface wb_if #(
  parameter int AW = wb_arb_pkg::WB_AW,
  parameter int DW = wb_arb_pkg::WB_DW
) ();

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_o;
  logic [DW-1:0]   dat_i;
  logic            stall;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, stall, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, stall, ack, err
  );

endinterface

// File: rtl/wb_arb_rr.sv
// rtl/wb_arb_rr.sv - round-robin picker with registered last-owner pointer
module wb_arb_rr
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   load,
  output logic [IW-1:0]          win,
  output logic [IW-1:0]          own
);

  logic [MAX_MASTERS-1:0] req_pad;

  assign req_pad = MAX_MASTERS'(req);
  assign win     = IW'(rr_next(req_pad, RR_IW'(own), NUM_MASTERS));

  // Reset to the last index so master 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own <= IW'(NUM_MASTERS - 1);
    end else if (load) begin
      own <= win;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin Wishbone pipelined arbiter sharing one slave among NUM_MASTERS masters
// Optional response watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_if.slave                    m [NUM_MASTERS],
  wb_if.master                   s,
  output logic [NUM_MASTERS-1:0] grant
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = cnt_w(MAX_OUTSTANDING);

  arb_state_t             state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          own;
  logic [IW-1:0]          win;
  logic                   load;
  logic                   owned;
  logic                   full;
  logic                   own_cyc;
  logic                   s_cyc;
  logic                   s_stb;
  logic                   inc;
  logic                   dec;
  logic                   wd_fire;

  logic [NUM_MASTERS-1:0] m_cyc;
  logic [NUM_MASTERS-1:0] m_stb;
  logic [NUM_MASTERS-1:0] m_we;
  logic [WB_AW-1:0]       m_adr [NUM_MASTERS];
  logic [WB_SW-1:0]       m_sel [NUM_MASTERS];
  logic [WB_DW-1:0]       m_dat [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] m_stall;
  logic [NUM_MASTERS-1:0] m_ack;
  logic [NUM_MASTERS-1:0] m_err;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign m_cyc[i]   = m[i].cyc;
    assign m_stb[i]   = m[i].stb;
    assign m_we[i]    = m[i].we;
    assign m_adr[i]   = m[i].adr;
    assign m_sel[i]   = m[i].sel;
    assign m_dat[i]   = m[i].dat_o;
    assign m[i].stall = m_stall[i];
    assign m[i].ack   = m_ack[i];
    assign m[i].err   = m_err[i];
    assign m[i].dat_i = (owned && own == IW'(i)) ? s.dat_i : '0;
  end

  wb_arb_rr #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (m_cyc),
    .load (load),
    .win  (win),
    .own  (own)
  );

  assign owned   = (state == OWNED);
  assign load    = (state == IDLE) && (|m_cyc);
  assign own_cyc = m_cyc[own];
  assign full    = (cnt == CW'(MAX_OUTSTANDING));

  // Dropping the owner's cyc aborts the burst on the slave in the same cycle.
  assign s_cyc = owned & own_cyc & ~wd_fire;
  assign s_stb = s_cyc & m_stb[own] & ~full;
  assign inc   = s_cyc & s_stb & ~s.stall;
  assign dec   = s_cyc & (s.ack | s.err);

  assign s.cyc   = s_cyc;
  assign s.stb   = s_stb;
  assign s.we    = owned & m_we[own];
  assign s.adr   = owned ? m_adr[own] : '0;
  assign s.sel   = owned ? m_sel[own] : '0;
  assign s.dat_o = owned ? m_dat[own] : '0;

  always_comb begin
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    if (owned) begin
      m_stall[own] = s.stall | full;
      m_ack[own]   = s_cyc & s.ack;
      m_err[own]   = (s_cyc & s.err) | wd_fire;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd;
  logic          wd_run;

  assign wd_run  = owned & own_cyc & (cnt != '0) & ~(s.ack | s.err);
  assign wd_fire = wd_run & (wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (!owned || s.ack || s.err || wd_fire) begin
      wd <= '0;
    end else if (wd_run) begin
      wd <= wd + WW'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|m_cyc) begin
            state <= OWNED;
            grant <= NUM_MASTERS'(1) << win;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            state <= IDLE;
            grant <= '0;
            cnt   <= '0;
          end else if (wd_fire) begin
            cnt <= '0;
          end else if (inc && !dec) begin
            cnt <= cnt + CW'(1);
          end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
